// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the CPU and the video fetch unit.
// Each access takes three cycles (IDLE, ISSUE, CAPTURE); video wins ties unless it has starved the CPU.
module mem_arbiter #(
    parameter int unsigned AW      = 20,
    parameter int unsigned DW      = 8,
    parameter int unsigned MAX_VID = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          owner_vid
);
    localparam int unsigned   CW       = $clog2(MAX_VID + 1);
    localparam logic [CW-1:0] VCNT_MAX = CW'(MAX_VID);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StCapture
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic          owner_vid_q, owner_vid_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] vid_rdata_q, vid_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          vid_ack_q, vid_ack_d;
    logic [CW-1:0] vcnt_q, vcnt_d;

    logic cpu_elig;
    logic vid_elig;
    logic vcnt_sat;
    logic grant_vid;
    logic grant_cpu;

    // A requester is masked in its own ack cycle so a still-high req is not served twice.
    always_comb begin
        cpu_elig  = cpu_req && !cpu_ack_q;
        vid_elig  = vid_req && !vid_ack_q;
        vcnt_sat  = (vcnt_q == VCNT_MAX);
        grant_vid = vid_elig && !(cpu_elig && vcnt_sat);
        grant_cpu = cpu_elig && !grant_vid;
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        owner_vid_d = owner_vid_q;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_ack_d   = 1'b0;
        vcnt_d      = vcnt_q;

        unique case (state_q)
            StIdle: begin
                if (!cpu_req) begin
                    vcnt_d = '0;
                end
                if (grant_vid) begin
                    mem_addr_d  = vid_addr;
                    mem_we_d    = 1'b0;
                    owner_vid_d = 1'b1;
                    state_d     = StIssue;
                    if (cpu_req && !vcnt_sat) begin
                        vcnt_d = vcnt_q + CW'(1);
                    end
                end else if (grant_cpu) begin
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    mem_we_d    = cpu_we;
                    owner_vid_d = 1'b0;
                    vcnt_d      = '0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                // RAM samples addr/we at this edge; the write strobe lasts one cycle only.
                mem_we_d = 1'b0;
                state_d  = StCapture;
            end
            StCapture: begin
                if (owner_vid_q) begin
                    vid_rdata_d = mem_q;
                    vid_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d = mem_q;
                    cpu_ack_d   = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            owner_vid_q <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vid_ack_q   <= 1'b0;
            vcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            owner_vid_q <= owner_vid_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_ack_q   <= vid_ack_d;
            vcnt_q      <= vcnt_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign owner_vid = owner_vid_q;
    assign cpu_rdata = cpu_rdata_q;
    assign vid_rdata = vid_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_ack   = vid_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM behind the DUT, directed scenarios, then random traffic,
// all checked against a transaction-timing model of the arbitration rules.
module tb_mem_arbiter;
    localparam int AW      = 20;
    localparam int DW      = 8;
    localparam int MAX_VID = 4;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic [DW-1:0] vid_rdata;
    logic          vid_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_q = '0;
    logic          owner_vid;

    always #5 clock = ~clock;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_VID(MAX_VID)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .owner_vid(owner_vid)
    );

    // System RAM with registered read; preload port used only while the DUT is in reset.
    logic [7:0]    ram [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;
    always @(posedge clock) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    // Reference model: memory contents plus the single outstanding access and its grant cycle.
    logic [7:0] ref_mem [logic [AW-1:0]];
    int checks = 0, failures = 0;
    int t = 0;
    bit pend, p_vid, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_data;
    int p_t, vcnt;
    bit e_cpu_ack, e_vid_ack, e_owner, cpu_known, vid_known;
    logic [DW-1:0] cpu_last, vid_last;
    int last_cpu_ack_t, last_vid_ack_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = 0; vcnt = 0; e_owner = 0;
        cpu_last = '0; vid_last = '0; cpu_known = 1; vid_known = 1;
        e_cpu_ack = 0; e_vid_ack = 0;
    endtask

    // Compare the outputs of cycle t against the access timeline: grant at p_t,
    // RAM command visible at p_t+1, write lands at the p_t+1 edge, ack in cycle p_t+3.
    task automatic check_cycle();
        bit issue;
        issue     = pend && (t == p_t + 1);
        e_cpu_ack = pend && (t == p_t + 3) && !p_vid;
        e_vid_ack = pend && (t == p_t + 3) && p_vid;
        if (issue) e_owner = p_vid;
        if (pend && t == p_t + 2 && p_we) ref_mem[p_addr] = p_wdata;
        chk("cpu_ack", 32'(cpu_ack), 32'(e_cpu_ack));
        chk("vid_ack", 32'(vid_ack), 32'(e_vid_ack));
        chk("mem_we", 32'(mem_we), 32'(issue && p_we));
        chk("owner_vid", 32'(owner_vid), 32'(e_owner));
        if (issue) chk("mem_addr", 32'(mem_addr), 32'(p_addr));
        if (issue && p_we) chk("mem_wdata", 32'(mem_wdata), 32'(p_wdata));
        if (e_cpu_ack) begin cpu_known = !p_we; cpu_last = p_data; last_cpu_ack_t = t; end
        if (e_vid_ack) begin vid_known = 1; vid_last = p_data; last_vid_ack_t = t; end
        if (cpu_known) chk("cpu_rdata", 32'(cpu_rdata), 32'(cpu_last));
        if (vid_known) chk("vid_rdata", 32'(vid_rdata), 32'(vid_last));
        if (pend && t == p_t + 3) pend = 0;
    endtask

    task automatic decide();
        bit ce, ve;
        if (pend) return;
        if (!cpu_req) vcnt = 0;
        ce = cpu_req && !e_cpu_ack;
        ve = vid_req && !e_vid_ack;
        if (ve && !(ce && vcnt == MAX_VID)) begin
            pend = 1; p_vid = 1; p_we = 0; p_addr = vid_addr; p_t = t;
            p_data = ref_mem[vid_addr];
            if (cpu_req && vcnt < MAX_VID) vcnt++;
        end else if (ce) begin
            pend = 1; p_vid = 0; p_we = cpu_we; p_addr = cpu_addr; p_wdata = cpu_wdata;
            p_t = t; vcnt = 0;
            p_data = cpu_we ? 8'h00 : ref_mem[cpu_addr];
        end
    endtask

    task automatic tick();
        decide();
        @(negedge clock);
        t++;
        check_cycle();
    endtask

    task automatic wait_ack(input bit vid, input int bound, output int n);
        n = 0;
        while (!(vid ? e_vid_ack : e_cpu_ack) && n < bound) begin
            tick();
            n++;
        end
        chk(vid ? "vid_ack_timeout" : "cpu_ack_timeout", 32'(vid ? vid_ack : cpu_ack), 32'd1);
    endtask

    task automatic drain();
        cpu_req = 0; vid_req = 0;
        for (int i = 0; i < 10 && pend; i++) tick();
        tick();
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1; pl_addr = a; pl_data = d; ref_mem[a] = d;
        @(negedge clock);
        pl_en = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) a = a | 20'hB8000;
        return a;
    endfunction

    initial begin
        int n, prev, tv, k;
        model_reset();
        @(negedge clock);
        for (int i = 0; i < 64; i++) begin
            preload(AW'(i), 8'($urandom));
            preload(20'hB8000 | AW'(i), 8'($urandom));
        end
        preload(20'hF0000, 8'hEA);
        preload(20'hB8000, 8'h41);
        preload(20'h00010, 8'h33);
        preload(20'h00005, 8'hA5);
        preload(20'h00006, 8'h5B);
        @(negedge clock);

        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack), 32'd0);
        chk("rst_owner", 32'(owner_vid), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        resetn = 1;
        t = 0;
        check_cycle();

        // CPU read alone: address after the grant edge, data two cycles later for one cycle.
        cpu_addr = 20'hF0000; cpu_we = 0; cpu_req = 1;
        tick();
        chk("t1_mem_addr", 32'(mem_addr), 32'hF0000);
        wait_ack(0, 8, n);
        chk("t1_latency", 32'(n), 32'd2);
        chk("t1_rdata", 32'(cpu_rdata), 32'hEA);
        cpu_req = 0;
        tick();
        chk("t1_ack_pulse", 32'(cpu_ack), 32'd0);
        drain();

        // Write then back-to-back read with req held through the ack cycle.
        cpu_addr = 20'h00100; cpu_we = 1; cpu_wdata = 8'h5A; cpu_req = 1;
        tick();
        chk("t2_we_on", 32'(mem_we), 32'd1);
        tick();
        chk("t2_we_off", 32'(mem_we), 32'd0);
        wait_ack(0, 8, n);
        prev = t;
        cpu_we = 0; cpu_wdata = 8'h00;
        tick();
        wait_ack(0, 8, n);
        chk("t2_readback", 32'(cpu_rdata), 32'h5A);
        chk("t6_ack_spacing", 32'(last_cpu_ack_t - prev), 32'd4);
        drain();

        // Simultaneous requests: video served first, CPU three cycles after.
        vid_addr = 20'hB8000; vid_req = 1;
        cpu_addr = 20'h00010; cpu_we = 0; cpu_req = 1;
        tick();
        chk("t3_owner_vid", 32'(owner_vid), 32'd1);
        wait_ack(1, 8, n);
        chk("t3_vid_rdata", 32'(vid_rdata), 32'h41);
        chk("t3_cpu_waiting", 32'(cpu_ack), 32'd0);
        tv = t;
        vid_req = 0;
        wait_ack(0, 8, n);
        chk("t3_cpu_rdata", 32'(cpu_rdata), 32'h33);
        chk("t3_gap", 32'(t - tv), 32'd3);
        drain();

        // Both requesters held: the CPU must keep making progress.
        vid_addr = 20'hB8001; vid_req = 1;
        cpu_addr = 20'h00007; cpu_we = 0; cpu_req = 1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cpu_ack === 1'b1) k++;
        end
        chk("t4_cpu_progress", 32'(k >= 4), 32'd1);
        drain();

        // Request dropped and address changed after the grant: the latched access completes.
        cpu_addr = 20'h00005; cpu_we = 0; cpu_req = 1;
        tick();
        cpu_req = 0; cpu_addr = 20'h00006;
        wait_ack(0, 8, n);
        chk("t7_latched_rdata", 32'(cpu_rdata), 32'hA5);
        drain();

        // Reset during the ISSUE cycle of a CPU write: strobe drops at once, no ack.
        cpu_addr = 20'h00020; cpu_we = 1; cpu_wdata = 8'hC3; cpu_req = 1;
        tick();
        chk("t5_we_before", 32'(mem_we), 32'd1);
        resetn = 0;
        #1;
        chk("t5_we_async", 32'(mem_we), 32'd0);
        @(negedge clock);
        chk("t5_no_ack", 32'(cpu_ack), 32'd0);
        @(negedge clock);
        chk("t5_no_ack2", 32'(cpu_ack), 32'd0);
        resetn = 1;
        model_reset();
        check_cycle();
        wait_ack(0, 8, n);
        chk("t5_restart_latency", 32'(n), 32'd3);
        cpu_we = 0;
        tick();
        wait_ack(0, 8, n);
        chk("t5_readback", 32'(cpu_rdata), 32'hC3);
        drain();

        // Random traffic from two well-behaved requesters.
        for (int i = 0; i < 800; i++) begin
            if (!cpu_req || e_cpu_ack) begin
                if ($urandom_range(0, 99) < 50) begin
                    cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = rand_addr(); cpu_wdata = 8'($urandom);
                end else begin
                    cpu_req = 0;
                end
            end else if ($urandom_range(0, 99) < 3) begin
                cpu_req = 0;
            end
            if (!vid_req || e_vid_ack) begin
                if ($urandom_range(0, 99) < 60) begin
                    vid_req = 1; vid_addr = rand_addr();
                end else begin
                    vid_req = 0;
                end
            end
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
